// File: rtl/audio_info_frame_parser_pkg.sv
// Shared definitions for the HDMI audio InfoFrame parser.
//   - packet constants (type code, frame length, byte positions)
//   - parser state encoding
//   - the decoded audio field bundle that is shadowed and published
package audio_info_frame_pkg;

   localparam logic [7:0] AIF_TYPE        = 8'h84;
   localparam int         AIF_FRAME_BYTES = 31;
   localparam int         CNT_W           = 5;

   // Position of each byte within the packet (HB0 is 0).
   localparam logic [CNT_W-1:0] IDX_PB0  = 5'd3;
   localparam logic [CNT_W-1:0] IDX_PB1  = 5'd4;
   localparam logic [CNT_W-1:0] IDX_PB2  = 5'd5;
   localparam logic [CNT_W-1:0] IDX_PB4  = 5'd7;
   localparam logic [CNT_W-1:0] IDX_PB5  = 5'd8;
   localparam logic [CNT_W-1:0] IDX_LAST = 5'(AIF_FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAY,
      DISCARD
   } state_e;

   typedef struct packed {
      logic [2:0] channel_count;
      logic [7:0] channel_allocation;
      logic       down_mix_inhibited;
      logic [3:0] level_shift;
      logic [1:0] lfe_playback_level;
   } aif_fields_t;

endpackage

// File: rtl/audio_info_frame_parser_if.sv
// Byte-stream bus feeding an InfoFrame parser.
//   in_valid : in_byte is valid this cycle (no backpressure)
//   in_sof   : marks HB0 of a packet, qualified by in_valid
//   in_byte  : packet byte HB0, HB1, HB2, PB0..PB27
// master drives the stream, slave (the parser) consumes it.
interface audio_info_frame_parser_if;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_byte;

   modport master (output in_valid, output in_sof, output in_byte);
   modport slave  (input  in_valid, input  in_sof, input  in_byte);
endinterface

// File: rtl/audio_info_frame_parser_checksum.sv
// infoframe_checksum: 8-bit modulo-256 accumulator shared by the InfoFrame
// parsers.
//   clk_pixel, reset : clock, asynchronous active-high reset
//   load_i           : restart the sum with byte_i
//   add_i            : add byte_i to the running sum
//   byte_i           : byte being accumulated
//   is_zero_o        : the sum including this cycle's load/add is zero, so the
//                      caller can judge a frame on the same cycle its last
//                      covered byte arrives
module infoframe_checksum (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic       load_i,
   input  logic       add_i,
   input  logic [7:0] byte_i,
   output logic       is_zero_o
);

   logic [7:0] acc_q;
   logic [7:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = byte_i;
      end else if (add_i) begin
         acc_d = acc_q + byte_i;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of block ordering.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         acc_q <= 8'h00;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign is_zero_o = (acc_d == 8'h00);

endmodule

// File: rtl/audio_info_frame_parser.sv
// audio_info_frame_parser: sink-side HDMI audio InfoFrame decoder.
// Checks header (type, version, length) and reserved fields byte by byte,
// sums HB0..PB[EXPECTED_LENGTH] and publishes the audio fields only when a
// complete frame sums to zero.
//   clk_pixel, reset   : clock, asynchronous active-high reset
//   in_if              : byte stream (in_valid / in_sof / in_byte)
//   frame_ok           : pulse, good frame accepted and fields updated
//   err_header         : pulse, header or reserved field mismatch
//   err_checksum       : pulse, sum nonzero at end of frame
//   err_abort          : pulse, new sof while a frame was in progress
//   info_valid         : sticky, set by the first frame_ok
//   channel_count .. lfe_playback_level : decoded fields of the last good frame
// Build option AUDIO_INFO_FRAME_PARSER_STATS_EN adds saturating good_count /
// bad_count outputs.
module audio_info_frame_parser
   import audio_info_frame_pkg::*;
#(
   parameter logic [7:0] EXPECTED_VERSION = 8'd1,
   parameter logic [4:0] EXPECTED_LENGTH  = 5'd10,
   parameter bit         CHECK_RESERVED   = 1'b1
) (
   input  logic                        clk_pixel,
   input  logic                        reset,
   audio_info_frame_parser_if.slave    in_if,
   output logic                        frame_ok,
   output logic                        err_header,
   output logic                        err_checksum,
   output logic                        err_abort,
   output logic                        info_valid,
   output logic [2:0]                  channel_count,
   output logic [7:0]                  channel_allocation,
   output logic                        down_mix_inhibited,
   output logic [3:0]                  level_shift,
   output logic [1:0]                  lfe_playback_level
`ifdef AUDIO_INFO_FRAME_PARSER_STATS_EN
   ,
   output logic [15:0]                 good_count,
   output logic [15:0]                 bad_count
`endif
);

   // Last byte index that still contributes to the checksum.
   localparam logic [CNT_W-1:0] IDX_SUM_END = IDX_PB0 + CNT_W'(EXPECTED_LENGTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_ok_q, frame_ok_d;
   logic             err_header_q, err_header_d;
   logic             err_checksum_q, err_checksum_d;
   logic             err_abort_q, err_abort_d;
   logic             info_valid_q, info_valid_d;
   aif_fields_t      shadow_q, shadow_d;
   aif_fields_t      fields_q, fields_d;

   logic             sum_load, sum_add, sum_zero;
   logic             field_bad;
   logic [7:0]       b;

   assign b = in_if.in_byte;

   infoframe_checksum u_checksum (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .load_i    (sum_load),
      .add_i     (sum_add),
      .byte_i    (b),
      .is_zero_o (sum_zero)
   );

   // Mismatch of the byte at position cnt_q (HB1, HB2, or reserved PB1/PB2).
   always_comb begin
      field_bad = 1'b0;
      case (cnt_q)
         5'd1:    field_bad = (b != EXPECTED_VERSION);
         5'd2:    field_bad = (b[4:0] != EXPECTED_LENGTH) || (b[7:5] != 3'b000);
         IDX_PB1: field_bad = CHECK_RESERVED && (b[7:4] != 4'h0);
         IDX_PB2: field_bad = CHECK_RESERVED && (b != 8'h00);
         default: field_bad = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path can
      // leave one unassigned, which would infer a latch.
      state_d        = state_q;
      cnt_d          = cnt_q;
      frame_ok_d     = 1'b0;
      err_header_d   = 1'b0;
      err_checksum_d = 1'b0;
      err_abort_d    = 1'b0;
      info_valid_d   = info_valid_q;
      shadow_d       = shadow_q;
      fields_d       = fields_q;
      sum_load       = 1'b0;
      sum_add        = 1'b0;

      if (in_if.in_valid) begin
         if (in_if.in_sof) begin
            // Any sof restarts the frame; only an active frame counts as abort.
            sum_load    = 1'b1;
            cnt_d       = 5'd1;
            state_d     = HDR;
            err_abort_d = (state_q == HDR) || (state_q == PAY);
            if (b != AIF_TYPE) begin
               state_d      = DISCARD;
               cnt_d        = '0;
               err_header_d = !err_abort_d;
            end
         end else begin
            unique case (state_q)
               IDLE, DISCARD: ;
               HDR, PAY: begin
                  sum_add = (cnt_q <= IDX_SUM_END);
                  cnt_d   = cnt_q + 5'd1;
                  if (cnt_q == 5'd2) state_d = PAY;
                  case (cnt_q)
                     IDX_PB1: shadow_d.channel_count = b[2:0];
                     IDX_PB4: shadow_d.channel_allocation = b;
                     IDX_PB5: begin
                        shadow_d.down_mix_inhibited = b[7];
                        shadow_d.level_shift        = b[6:3];
                        shadow_d.lfe_playback_level = b[1:0];
                     end
                     default: ;
                  endcase
                  if (field_bad) begin
                     err_header_d = 1'b1;
                     state_d      = DISCARD;
                     cnt_d        = '0;
                  end else if (cnt_q == IDX_LAST) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     if (sum_zero) begin
                        frame_ok_d   = 1'b1;
                        fields_d     = shadow_q;
                        info_valid_d = 1'b1;
                     end else begin
                        err_checksum_d = 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         frame_ok_q     <= 1'b0;
         err_header_q   <= 1'b0;
         err_checksum_q <= 1'b0;
         err_abort_q    <= 1'b0;
         info_valid_q   <= 1'b0;
         shadow_q       <= '0;
         fields_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         frame_ok_q     <= frame_ok_d;
         err_header_q   <= err_header_d;
         err_checksum_q <= err_checksum_d;
         err_abort_q    <= err_abort_d;
         info_valid_q   <= info_valid_d;
         shadow_q       <= shadow_d;
         fields_q       <= fields_d;
      end
   end

   assign frame_ok           = frame_ok_q;
   assign err_header         = err_header_q;
   assign err_checksum       = err_checksum_q;
   assign err_abort          = err_abort_q;
   assign info_valid         = info_valid_q;
   assign channel_count      = fields_q.channel_count;
   assign channel_allocation = fields_q.channel_allocation;
   assign down_mix_inhibited = fields_q.down_mix_inhibited;
   assign level_shift        = fields_q.level_shift;
   assign lfe_playback_level = fields_q.lfe_playback_level;

`ifdef AUDIO_INFO_FRAME_PARSER_STATS_EN
   logic [15:0] good_q;
   logic [15:0] bad_q;

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         good_q <= '0;
         bad_q  <= '0;
      end else begin
         if (frame_ok_d && (good_q != 16'hFFFF)) good_q <= good_q + 16'd1;
         if ((err_header_d || err_checksum_d || err_abort_d) && (bad_q != 16'hFFFF))
            bad_q <= bad_q + 16'd1;
      end
   end

   assign good_count = good_q;
   assign bad_count  = bad_q;
`endif

endmodule

// File: tb/tb_audio_info_frame_parser.sv
// Directed bench for audio_info_frame_parser. A frame-level model (byte
// buffer + whole-frame arithmetic) predicts every output each cycle; a few
// hand-computed literals pin the model on the key scenarios.
module tb_audio_info_frame_parser;

   typedef logic [7:0] frame_t [0:30];

   logic clk   = 1'b0;
   logic reset = 1'b1;

   audio_info_frame_parser_if bus ();

   logic       frame_ok, err_header, err_checksum, err_abort, info_valid;
   logic [2:0] channel_count;
   logic [7:0] channel_allocation;
   logic       down_mix_inhibited;
   logic [3:0] level_shift;
   logic [1:0] lfe_playback_level;
`ifdef AUDIO_INFO_FRAME_PARSER_STATS_EN
   logic [15:0] good_count, bad_count;
`endif

   audio_info_frame_parser dut (
      .clk_pixel          (clk),
      .reset              (reset),
      .in_if              (bus),
      .frame_ok           (frame_ok),
      .err_header         (err_header),
      .err_checksum       (err_checksum),
      .err_abort          (err_abort),
      .info_valid         (info_valid),
      .channel_count      (channel_count),
      .channel_allocation (channel_allocation),
      .down_mix_inhibited (down_mix_inhibited),
      .level_shift        (level_shift),
      .lfe_playback_level (lfe_playback_level)
`ifdef AUDIO_INFO_FRAME_PARSER_STATS_EN
      ,
      .good_count         (good_count),
      .bad_count          (bad_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [7:0] m_fb[$];
   bit         m_active = 1'b0;
   logic       e_frame_ok = 0, e_err_header = 0, e_err_checksum = 0, e_err_abort = 0;
   logic       e_info_valid = 0;
   logic [2:0] e_cc = 0;
   logic [7:0] e_ca = 0;
   logic       e_dm = 0;
   logic [3:0] e_ls = 0;
   logic [1:0] e_lfe = 0;
   int         e_good = 0, e_bad = 0;

   task automatic model_step();
      logic [7:0] s;
      int         idx;
      bit         hit;
      bit         wrong;
      if (reset) begin
         m_fb.delete();
         m_active = 0;
         {e_frame_ok, e_err_header, e_err_checksum, e_err_abort, e_info_valid} = '0;
         e_cc = 0; e_ca = 0; e_dm = 0; e_ls = 0; e_lfe = 0;
         e_good = 0; e_bad = 0;
         return;
      end
      {e_frame_ok, e_err_header, e_err_checksum, e_err_abort} = '0;
      hit = 0;
      if (bus.in_valid) begin
         if (bus.in_sof) begin
            e_err_abort = m_active;
            m_fb.delete();
            m_fb.push_back(bus.in_byte);
            m_active = 1;
            hit = 1;
         end else if (m_active) begin
            m_fb.push_back(bus.in_byte);
            hit = 1;
         end
      end
      if (hit) begin
         idx = m_fb.size() - 1;
         case (idx)
            0:       wrong = (m_fb[0] != 8'h84);
            1:       wrong = (m_fb[1] != 8'h01);
            2:       wrong = (m_fb[2] != 8'h0A);
            4:       wrong = (m_fb[4][7:4] != 4'h0);
            5:       wrong = (m_fb[5] != 8'h00);
            default: wrong = 0;
         endcase
         if (wrong) begin
            m_active = 0;
            if (!e_err_abort) e_err_header = 1;
         end else if (idx == 30) begin
            m_active = 0;
            s = 8'h00;
            for (int i = 0; i <= 13; i++) s = s + m_fb[i];
            if (s == 8'h00) begin
               e_frame_ok   = 1;
               e_info_valid = 1;
               e_cc  = m_fb[4][2:0];
               e_ca  = m_fb[7];
               e_dm  = m_fb[8][7];
               e_ls  = m_fb[8][6:3];
               e_lfe = m_fb[8][1:0];
            end else begin
               e_err_checksum = 1;
            end
         end
      end
      if (e_frame_ok && e_good < 65535) e_good++;
      if ((e_err_header || e_err_checksum || e_err_abort) && e_bad < 65535) e_bad++;
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      check("frame_ok", frame_ok, e_frame_ok);
      check("err_header", err_header, e_err_header);
      check("err_checksum", err_checksum, e_err_checksum);
      check("err_abort", err_abort, e_err_abort);
      check("info_valid", info_valid, e_info_valid);
      check("channel_count", channel_count, e_cc);
      check("channel_allocation", channel_allocation, e_ca);
      check("down_mix_inhibited", down_mix_inhibited, e_dm);
      check("level_shift", level_shift, e_ls);
      check("lfe_playback_level", lfe_playback_level, e_lfe);
`ifdef AUDIO_INFO_FRAME_PARSER_STATS_EN
      check("good_count", good_count, e_good);
      check("bad_count", bad_count, e_bad);
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic v, input logic s, input logic [7:0] b);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_sof   = s;
      bus.in_byte  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_frame(input frame_t f, input int first, input int last, input bit gaps);
      for (int i = first; i <= last; i++) begin
         if (gaps)
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 0; g++)
               send_byte(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
         send_byte(1'b1, (i == 0), f[i]);
      end
   endtask

   function automatic frame_t default_frame();
      frame_t f;
      foreach (f[i]) f[i] = 8'h00;
      f[0] = 8'h84; f[1] = 8'h01; f[2] = 8'h0A; f[3] = 8'h70; f[4] = 8'h01;
      return f;
   endfunction

   initial begin
      frame_t f_def, f_fld, f_tmp;
      int     bad_idx [6] = '{1, 2, 2, 4, 5, 4};
      logic [7:0] bad_val [6] = '{8'h02, 8'h2A, 8'h0B, 8'h11, 8'h01, 8'h08};

      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_byte  = 8'h00;
      f_def = default_frame();
      f_fld = f_def;
      f_fld[3] = 8'h94; f_fld[7] = 8'h13; f_fld[8] = 8'hC9;

      repeat (3) @(negedge clk);
      check("reset frame_ok", frame_ok, 0);
      check("reset info_valid", info_valid, 0);
      check("reset channel_count", channel_count, 0);
      reset = 1'b0;

      // Valid bytes without sof in IDLE are dropped.
      send_byte(1'b1, 1'b0, 8'h84);
      send_byte(1'b1, 1'b0, 8'h01);

      // Good default frame.
      send_frame(f_def, 0, 30, 0);
      @(negedge clk);
      check("default frame_ok", frame_ok, 1);
      check("default channel_count", channel_count, 1);
      check("default channel_allocation", channel_allocation, 8'h00);
      check("default info_valid", info_valid, 1);

      // Field decode.
      send_frame(f_fld, 0, 30, 0);
      @(negedge clk);
      check("fields frame_ok", frame_ok, 1);
      check("fields channel_allocation", channel_allocation, 8'h13);
      check("fields down_mix", down_mix_inhibited, 1);
      check("fields level_shift", level_shift, 4'h9);
      check("fields lfe", lfe_playback_level, 2'b01);

      // Bad checksum keeps previous fields.
      f_tmp = f_def; f_tmp[3] = 8'h71;
      send_frame(f_tmp, 0, 30, 0);
      @(negedge clk);
      check("cksum err_checksum", err_checksum, 1);
      check("cksum frame_ok", frame_ok, 0);
      check("cksum channel_allocation kept", channel_allocation, 8'h13);
      check("cksum info_valid kept", info_valid, 1);

      // Bad HB0, rest dropped, next frame good.
      f_tmp = f_def; f_tmp[0] = 8'h82;
      send_frame(f_tmp, 0, 0, 0);
      @(negedge clk);
      check("hb0 err_header", err_header, 1);
      send_frame(f_tmp, 1, 30, 0);
      send_frame(f_def, 0, 30, 0);
      @(negedge clk);
      check("after hb0 frame_ok", frame_ok, 1);
      check("after hb0 channel_allocation", channel_allocation, 8'h00);

      // Other header / reserved violations (model-checked).
      for (int k = 0; k < 6; k++) begin
         f_tmp = f_def;
         f_tmp[bad_idx[k]] = bad_val[k];
         send_frame(f_tmp, 0, 30, 0);
      end

      // Checksum coverage boundary: PB10 counted, PB11 onward ignored.
      f_tmp = f_def; f_tmp[13] = 8'h01; f_tmp[3] = 8'h6F; f_tmp[14] = 8'hFF; f_tmp[30] = 8'h5A;
      send_frame(f_tmp, 0, 30, 0);
      @(negedge clk);
      check("pb10 covered frame_ok", frame_ok, 1);
      f_tmp = f_def; f_tmp[13] = 8'h01;
      send_frame(f_tmp, 0, 30, 0);
      @(negedge clk);
      check("pb10 covered err_checksum", err_checksum, 1);

      // Abort at PB10, restart with a good frame.
      send_frame(f_def, 0, 12, 0);
      send_frame(f_fld, 0, 0, 0);
      @(negedge clk);
      check("abort err_abort", err_abort, 1);
      send_frame(f_fld, 1, 30, 0);
      @(negedge clk);
      check("abort then frame_ok", frame_ok, 1);

      // sof while discarding: restart without abort pulse.
      f_tmp = f_def; f_tmp[1] = 8'h07;
      send_frame(f_tmp, 0, 8, 0);
      send_frame(f_def, 0, 0, 0);
      @(negedge clk);
      check("discard no err_abort", err_abort, 0);
      send_frame(f_def, 1, 30, 0);

      // sof on the PB27 slot aborts; back-to-back frames.
      send_frame(f_fld, 0, 29, 0);
      send_frame(f_def, 0, 30, 0);
      send_frame(f_fld, 0, 30, 0);

      // Abort scenario with random gaps.
      send_frame(f_def, 0, 12, 1);
      send_frame(f_def, 0, 30, 1);
      @(negedge clk);
      check("gaps frame_ok", frame_ok, 1);
      check("gaps channel_allocation", channel_allocation, 8'h00);

      // Reset at PB15 of a field frame that follows good fields.
      send_frame(f_fld, 0, 30, 1);
      send_frame(f_fld, 0, 18, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst info_valid", info_valid, 0);
      check("rst channel_allocation", channel_allocation, 0);
      check("rst level_shift", level_shift, 0);
      check("rst down_mix", down_mix_inhibited, 0);
      check("rst pulses", {frame_ok, err_header, err_checksum, err_abort}, 0);
`ifdef AUDIO_INFO_FRAME_PARSER_STATS_EN
      check("rst good_count", good_count, 0);
      check("rst bad_count", bad_count, 0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send_frame(f_def, 19, 30, 0);
      send_frame(f_fld, 0, 30, 0);
      @(negedge clk);
      check("post reset frame_ok", frame_ok, 1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
